// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared encodings, phase/state enums and bus timing helper for the I2C command controller
package i2c_pkg;

  // Command encodings presented on cmd
  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  // Quarter-bit phase within a START, STOP or data bit
  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_e;

  // Controller FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_STOP  = 3'd2,
    ST_XFER  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // clk cycles per quarter of an SCL period
  function automatic int calc_divider(input int clk_freq, input int bus_clk);
    return (clk_freq / bus_clk) / 4;
  endfunction

endpackage

// File: rtl/i2c_quarter_timer.sv
// rtl/i2c_quarter_timer.sv - quarter-bit counter with SCL clock-stretch hold
module i2c_quarter_timer
  import i2c_pkg::*;
#(
  parameter int DIVIDER = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,        // idle: park at ph0, count 0
  input  logic       scl_rel,      // current quarter releases SCL and waits for it high
  input  logic       scl_high,     // synchronized SCL level
  output logic [1:0] phase,
  output logic       quarter_end
);

  localparam int CW = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [1:0]    age_q, age_d;   // cycles since SCL was released, saturates at 2
  logic          at_last;
  logic          settled;
  logic          hold;

  // The synchronizer still shows the pre-release (low) level for two cycles after
  // SCL is let go, so a low is only treated as a stretch once it has settled.
  always_comb begin
    at_last     = (cnt_q == CW'(DIVIDER - 1));
    settled     = (age_q == 2'd2);
    hold        = scl_rel && settled && !scl_high;
    quarter_end = at_last && !hold && !(scl_rel && !settled);
  end

  // Next counter, phase and settle-age values
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    age_d   = age_q;
    if (clear) begin
      cnt_d   = '0;
      phase_d = PH0;
      age_d   = 2'd0;
    end else if (hold) begin
      cnt_d = '0;
    end else if (quarter_end) begin
      cnt_d   = '0;
      phase_d = phase_q + 2'd1;
      age_d   = 2'd0;
    end else begin
      if (!at_last) begin
        cnt_d = cnt_q + CW'(1);
      end
      if (scl_rel && !settled) begin
        age_d = age_q + 2'd1;
      end
    end
  end

  // Timer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= PH0;
      age_q   <= 2'd0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      age_q   <= age_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/i2c_cmd_ctrl.sv
// rtl/i2c_cmd_ctrl.sv - command-level I2C master: START/STOP/WRITE/READ sequencing of open-drain SCL/SDA
module i2c_cmd_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BUS_CLK  = 400_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rd_data,
  output logic       rsp_nack,
  output logic       rsp_err,
  output logic       busy,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam int DIVIDER = calc_divider(CLK_FREQ, BUS_CLK);

  state_e     state_q, state_d;
  logic       busy_q, busy_d;
  logic       sda_hold_q, sda_hold_d;   // SDA drive held between bits and commands
  logic [7:0] sh_q, sh_d;               // write byte out / read byte in, MSB first
  logic       is_read_q, is_read_d;
  logic       nack_q, nack_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rsp_nack_q, rsp_nack_d;
  logic       rsp_err_q, rsp_err_d;

  logic scl_meta_q, scl_sync_q, sda_meta_q, sda_sync_q;
  logic [1:0] phase;
  logic quarter_end;
  logic scl_rel;
  logic accept;
  logic last_q;
  logic bit_oe;
  logic timer_clear;

  // Two-flop synchronizers for the raw pad inputs; idle bus reads high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_in;
      scl_sync_q <= scl_meta_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign rsp_valid   = (state_q == ST_RESP);
  assign accept      = cmd_valid && cmd_ready;
  assign last_q      = quarter_end && (phase == PH3);
  assign timer_clear = !((state_q == ST_START) || (state_q == ST_STOP) || (state_q == ST_XFER));

  // SDA drive for the current data bit: byte bits for WRITE, ACK/NACK for READ
  assign bit_oe = (bit_q == 4'd8) ? (is_read_q && !nack_q) : (!is_read_q && !sh_q[7]);

  i2c_quarter_timer #(
    .DIVIDER(DIVIDER)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (timer_clear),
    .scl_rel    (scl_rel),
    .scl_high   (scl_sync_q),
    .phase      (phase),
    .quarter_end(quarter_end)
  );

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      sda_hold_q <= 1'b0;
      sh_q       <= 8'h00;
      is_read_q  <= 1'b0;
      nack_q     <= 1'b0;
      bit_q      <= 4'd0;
      rd_data_q  <= 8'h00;
      rsp_nack_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      sda_hold_q <= sda_hold_d;
      sh_q       <= sh_d;
      is_read_q  <= is_read_d;
      nack_q     <= nack_d;
      bit_q      <= bit_d;
      rd_data_q  <= rd_data_d;
      rsp_nack_q <= rsp_nack_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state logic; data commands and STOP on an unowned bus go straight to RESP
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          case (cmd)
            CMD_START: state_d = ST_START;
            CMD_STOP:  state_d = busy_q ? ST_STOP : ST_RESP;
            CMD_WRITE: state_d = busy_q ? ST_XFER : ST_RESP;
            CMD_READ:  state_d = busy_q ? ST_XFER : ST_RESP;
            default:   state_d = ST_RESP;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START, ST_STOP: begin
        if (last_q) state_d = ST_RESP;
      end
      ST_XFER: begin
        if (last_q && (bit_q == 4'd8)) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: capture the command, shift bits, collect results
  always_comb begin
    busy_d     = busy_q;
    sda_hold_d = sda_hold_q;
    sh_d       = sh_q;
    is_read_d  = is_read_q;
    nack_d     = nack_q;
    bit_d      = bit_q;
    rd_data_d  = rd_data_q;
    rsp_nack_d = rsp_nack_q;
    rsp_err_d  = rsp_err_q;
    if (accept) begin
      rsp_err_d  = (cmd != CMD_START) && !busy_q;
      rsp_nack_d = 1'b0;
      sh_d       = wr_data;
      is_read_d  = (cmd == CMD_READ);
      nack_d     = cmd_nack;
      bit_d      = 4'd0;
    end
    case (state_q)
      ST_START: begin
        if (last_q) begin
          busy_d     = 1'b1;
          sda_hold_d = 1'b1;
        end
      end
      ST_STOP: begin
        if (last_q) begin
          busy_d     = 1'b0;
          sda_hold_d = 1'b0;
        end
      end
      ST_XFER: begin
        if (last_q) begin
          sda_hold_d = bit_oe;
          sh_d       = {sh_q[6:0], sda_sync_q};
          bit_d      = bit_q + 4'd1;
          if ((bit_q == 4'd7) && is_read_q) rd_data_d = {sh_q[6:0], sda_sync_q};
          if ((bit_q == 4'd8) && !is_read_q) rsp_nack_d = sda_sync_q;
        end
      end
      default: ;
    endcase
  end

  // Pad drive per state and phase; outside a sequence the lines keep their last level
  always_comb begin
    scl_oe  = busy_q;
    sda_oe  = sda_hold_q;
    scl_rel = 1'b0;
    case (state_q)
      ST_START: begin
        unique case (phase)
          PH0: sda_oe = 1'b0;
          PH1: begin scl_oe = 1'b0; sda_oe = 1'b0; scl_rel = 1'b1; end
          PH2: begin scl_oe = 1'b0; sda_oe = 1'b1; end
          PH3: begin scl_oe = 1'b1; sda_oe = 1'b1; end
          default: ;
        endcase
      end
      ST_STOP: begin
        unique case (phase)
          PH0: begin scl_oe = 1'b1; sda_oe = 1'b1; end
          PH1: begin scl_oe = 1'b0; sda_oe = 1'b1; scl_rel = 1'b1; end
          PH2: begin scl_oe = 1'b0; sda_oe = 1'b1; end
          PH3: begin scl_oe = 1'b0; sda_oe = 1'b0; end
          default: ;
        endcase
      end
      ST_XFER: begin
        unique case (phase)
          PH0: begin scl_oe = 1'b1; sda_oe = sda_hold_q; end
          PH1: begin scl_oe = 1'b1; sda_oe = bit_oe; end
          PH2: begin scl_oe = 1'b0; sda_oe = bit_oe; scl_rel = 1'b1; end
          PH3: begin scl_oe = 1'b0; sda_oe = bit_oe; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign busy     = busy_q;
  assign rd_data  = rd_data_q;
  assign rsp_nack = rsp_nack_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_i2c_cmd_ctrl.sv
// tb/tb_i2c_cmd_ctrl.sv - self-checking bench for i2c_cmd_ctrl with pull-up bus and slave model
module tb_i2c_cmd_ctrl;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd = 2'b00;
  logic [7:0] wr_data = 8'h00;
  logic       cmd_nack = 1'b0;
  logic       rsp_valid;
  logic [7:0] rd_data;
  logic       rsp_nack;
  logic       rsp_err;
  logic       busy;
  logic       scl_in, sda_in;
  logic       scl_oe, sda_oe;
  logic       dev_scl = 1'b1;
  logic       dev_sda = 1'b1;

  int total = 0;
  int bad   = 0;

  // Open-drain bus with pull-up
  assign scl_in = ~scl_oe & dev_scl;
  assign sda_in = ~sda_oe & dev_sda;

  always #5 clk = ~clk;

  i2c_cmd_ctrl #(
    .CLK_FREQ(1_600_000),
    .BUS_CLK (100_000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd      (cmd),
    .wr_data  (wr_data),
    .cmd_nack (cmd_nack),
    .rsp_valid(rsp_valid),
    .rd_data  (rd_data),
    .rsp_nack (rsp_nack),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Issue one command, play the slave, and return when rsp_valid is seen (or budget runs out).
  // sb >= 0 selects a data bit whose ph2 the slave stretches by slow cycles.
  task automatic run_cmd(input logic [1:0] c, input logic [7:0] wd, input logic cn,
                         input logic [7:0] sbyte, input logic sack_n, input int sb, input int slow,
                         output int lat, output logic [8:0] oe_bits, output int k_sda,
                         output int k_scl, output logic saw_oe);
    int w, extra, bs, p3;
    logic xfer;
    xfer    = c[1];
    extra   = (sb >= 0) ? slow + 2 : 0;
    lat     = -1;
    oe_bits = '0;
    k_sda   = -1;
    k_scl   = -1;
    saw_oe  = 1'b0;
    w       = 0;
    @(negedge clk);
    while (!cmd_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd       = c;
    wr_data   = wd;
    cmd_nack  = cn;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wr_data   = ~wd;
    cmd_nack  = ~cn;
    cmd       = 2'($urandom_range(0, 3));
    for (int k = 0; k < 400; k++) begin
      if (rsp_valid) begin
        lat = k;
        break;
      end
      if (scl_oe || sda_oe) saw_oe = 1'b1;
      if (sda_oe && k_sda < 0) k_sda = k;
      if (scl_oe && k_scl < 0) k_scl = k;
      if (xfer) begin
        for (int b = 0; b < 9; b++) begin
          bs = 16 * b + ((sb >= 0 && b > sb) ? extra : 0);
          p3 = bs + 12 + ((b == sb) ? extra : 0);
          if (k == bs) begin
            if (b < 8) dev_sda = (c == CMD_READ) ? sbyte[7-b] : 1'b1;
            else       dev_sda = (c == CMD_READ) ? 1'b1 : sack_n;
          end
          if (k == p3 + 1) oe_bits[8-b] = sda_oe;
          if (b == sb && k == bs + 4) dev_scl = 1'b0;
          if (b == sb && k == bs + 8 + slow) dev_scl = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    dev_sda = 1'b1;
    dev_scl = 1'b1;
  endtask

  initial begin
    int lat, k_sda, k_scl, quiet;
    logic [8:0] oe_bits;
    logic saw;
    logic [7:0] wd, sbyte, last_rd;
    logic ack_n, cn;
    logic [1:0] ill [3];

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl_oe", 32'(scl_oe), 32'd0);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rsp_nack", 32'(rsp_nack), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Illegal commands on an unowned bus
    ill[0] = CMD_WRITE;
    ill[1] = CMD_READ;
    ill[2] = CMD_STOP;
    for (int i = 0; i < 3; i++) begin
      run_cmd(ill[i], 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, lat, oe_bits, k_sda, k_scl, saw);
      check("ill_lat", 32'(lat), 32'd0);
      check("ill_err", 32'(rsp_err), 32'd1);
      check("ill_nack", 32'(rsp_nack), 32'd0);
      check("ill_no_oe", 32'(saw), 32'd0);
      check("ill_busy", 32'(busy), 32'd0);
    end

    // START from idle
    run_cmd(CMD_START, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, lat, oe_bits, k_sda, k_scl, saw);
    check("start_lat", 32'(lat), 32'd16);
    check("start_sda_rise", 32'(k_sda), 32'd8);
    check("start_scl_rise", 32'(k_scl), 32'd12);
    check("start_err", 32'(rsp_err), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("rsp_one_cycle", 32'(rsp_valid), 32'd0);

    // WRITE 0xA5 with ACK
    run_cmd(CMD_WRITE, 8'hA5, 1'b0, 8'h00, 1'b0, -1, 0, lat, oe_bits, k_sda, k_scl, saw);
    check("wr_a5_lat", 32'(lat), 32'd144);
    check("wr_a5_oe", 32'(oe_bits), 32'({~8'hA5, 1'b0}));
    check("wr_a5_nack", 32'(rsp_nack), 32'd0);
    check("wr_a5_err", 32'(rsp_err), 32'd0);

    // READ 0x3C, master NACKs
    run_cmd(CMD_READ, 8'h00, 1'b1, 8'h3C, 1'b0, -1, 0, lat, oe_bits, k_sda, k_scl, saw);
    check("rd_3c_lat", 32'(lat), 32'd144);
    check("rd_3c_data", 32'(rd_data), 32'h3C);
    check("rd_3c_oe", 32'(oe_bits), 32'd0);
    check("rd_3c_nack", 32'(rsp_nack), 32'd0);
    last_rd = 8'h3C;

    // Randomized writes and reads
    for (int i = 0; i < 4; i++) begin
      wd    = 8'($urandom);
      ack_n = 1'($urandom_range(0, 1));
      run_cmd(CMD_WRITE, wd, 1'b0, 8'h00, ack_n, -1, 0, lat, oe_bits, k_sda, k_scl, saw);
      check("rnd_wr_lat", 32'(lat), 32'd144);
      check("rnd_wr_oe", 32'(oe_bits), 32'({~wd, 1'b0}));
      check("rnd_wr_nack", 32'(rsp_nack), 32'(ack_n));
      check("rnd_wr_rd_held", 32'(rd_data), 32'(last_rd));
      sbyte = 8'($urandom);
      cn    = 1'($urandom_range(0, 1));
      run_cmd(CMD_READ, 8'h00, cn, sbyte, 1'b0, -1, 0, lat, oe_bits, k_sda, k_scl, saw);
      check("rnd_rd_lat", 32'(lat), 32'd144);
      check("rnd_rd_data", 32'(rd_data), 32'(sbyte));
      check("rnd_rd_oe", 32'(oe_bits), 32'({8'h00, ~cn}));
      check("rnd_rd_nack", 32'(rsp_nack), 32'd0);
      last_rd = sbyte;
    end

    // WRITE with SCL held low 20 cycles in ph2 of the third bit
    wd = 8'h5A;
    run_cmd(CMD_WRITE, wd, 1'b0, 8'h00, 1'b0, 2, 20, lat, oe_bits, k_sda, k_scl, saw);
    check("str_lat", 32'(lat), 32'd166);
    check("str_oe", 32'(oe_bits), 32'({~wd, 1'b0}));
    check("str_nack", 32'(rsp_nack), 32'd0);
    check("str_rd_held", 32'(rd_data), 32'(last_rd));

    // Repeated START, then STOP
    run_cmd(CMD_START, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, lat, oe_bits, k_sda, k_scl, saw);
    check("rstart_lat", 32'(lat), 32'd16);
    check("rstart_err", 32'(rsp_err), 32'd0);
    check("rstart_busy", 32'(busy), 32'd1);
    run_cmd(CMD_STOP, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, lat, oe_bits, k_sda, k_scl, saw);
    check("stop_lat", 32'(lat), 32'd16);
    check("stop_err", 32'(rsp_err), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_scl_oe", 32'(scl_oe), 32'd0);
    check("stop_sda_oe", 32'(sda_oe), 32'd0);
    check("stop_scl_line", 32'(scl_in), 32'd1);
    check("stop_sda_line", 32'(sda_in), 32'd1);

    // Reset in the middle of a READ
    run_cmd(CMD_START, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, lat, oe_bits, k_sda, k_scl, saw);
    check("pre_rd_start_lat", 32'(lat), 32'd16);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = CMD_READ;
    cmd_nack  = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (16 * 4 + 5) @(posedge clk);
    #1;
    check("pre_rst_scl_oe", 32'(scl_oe), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_scl_oe", 32'(scl_oe), 32'd0);
    check("async_sda_oe", 32'(sda_oe), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    quiet = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid || scl_oe || sda_oe) quiet++;
    end
    check("post_rst_quiet", 32'(quiet), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_ctrl.md
# i2c_cmd_ctrl

Command-level I2C master controller that sequences the open-drain SCL/SDA pads. It accepts START, STOP, WRITE-byte and READ-byte commands over a valid/ready handshake, generates quarter-period bus timing with clock-stretch support, and returns one response per command. It sits between a register/bus-facing front end and the board-level SB_IO tristate pads. Those pads are instantiated at top level with D_OUT tied to 0 and OUTPUT_ENABLE driven from scl_oe and sda_oe.

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- BUS_CLK, 400_000, SCL frequency in Hz; DIVIDER = (CLK_FREQ/BUS_CLK)/4 clk cycles per quarter bit, DIVIDER ≥ 2
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller idle, can accept
- cmd  in  2  00 START, 01 STOP, 10 WRITE, 11 READ
- wr_data  in  8  byte for WRITE, sent MSB first
- cmd_nack  in  1  READ only: 1 = master NACKs after the byte, 0 = ACK
- rsp_valid  out  1  one-cycle pulse, command complete
- rd_data  out  8  READ result, valid with rsp_valid and held until next READ
- rsp_nack  out  1  WRITE: slave NACKed; 0 for all other commands
- rsp_err  out  1  illegal command for the current bus state
- busy  out  1  bus owned (between START and STOP)
- scl_in, sda_in  in  1  raw pad inputs, asynchronous
- scl_oe, sda_oe  out  1  1 = pull line low, 0 = release

## Operation
- scl_in/sda_in pass through 2-flop synchronizers; all decisions use the synchronized values.
- States: IDLE, START, STOP, XFER (9 bits), RESP.
- Each START, STOP and bit is 4 quarters (ph0..ph3) of DIVIDER cycles each, driven by a quarter counter.
- START: ph0 release SDA; ph1 release SCL (stretch wait); ph2 SDA low; ph3 SCL low. Ends with SCL and SDA low, and busy=1.
  - From IDLE, SCL is already released.
  - Issuing START while busy is a repeated start.
- STOP: ph0 SCL low, SDA low; ph1 release SCL (stretch wait); ph2 hold; ph3 release SDA. Ends with both lines released, busy=0.
- Bit: ph0 SCL low, SDA unchanged; ph1 SCL low, SDA set to bit value; ph2 release SCL (stretch wait); ph3 SCL high, sample sda_in on the last cycle of ph3.
- WRITE: bits 1–8 drive wr_data MSB first (sda_oe = ~bit). Bit 9 releases SDA; the sample is loaded into rsp_nack.
- READ: bits 1–8 release SDA and shift samples into rd_data MSB first. Bit 9 drives sda_oe = ~cmd_nack.
- Clock stretch: in any quarter that releases SCL, the quarter counter holds at 0 while synchronized scl_in=0. It counts once scl_in is seen high. There is no timeout.
- Illegal commands: WRITE, READ or STOP with busy=0 produce no bus activity. They go directly to RESP with rsp_err=1.
- Commands arriving while cmd_ready=0 are not accepted; the issuer must hold cmd_valid.

## Timing
- Reset values: scl_oe=0, sda_oe=0, cmd_ready=1, rsp_valid=0, rd_data=0, rsp_nack=0, rsp_err=0, busy=0, state IDLE.
- Accept occurs on a cycle with cmd_valid & cmd_ready. cmd_ready drops the next cycle, and ph0 starts that cycle.
- Unstretched duration:
  - START/STOP: 4·DIVIDER cycles.
  - WRITE/READ: 36·DIVIDER cycles.
  - rsp_valid is asserted on the cycle after the last ph3 cycle.
  - Illegal command: rsp_valid on the cycle after accept.
- cmd_ready reasserts in the same cycle as rsp_valid. A new command may be accepted in that cycle.
- Stretch adds (low cycles + 2 synchronizer cycles) to the affected quarter.
- wr_data and cmd_nack are registered at accept; later changes are ignored.
- Reset asserted mid-command: both oe outputs drop to 0 immediately (asynchronous), and the in-flight command is discarded with no rsp_valid.

## Structure
- Shared package i2c_pkg holds:
  - command encodings CMD_START/STOP/WRITE/READ
  - the phase enum
  - the DIVIDER computation function
- Sub-module i2c_quarter_timer holds the DIVIDER counter with hold input (stretch) and outputs phase[1:0] and quarter_end.
- The FSM, shift register and bit counter live in i2c_cmd_ctrl.

## Test plan
Simulation parameters: CLK_FREQ=1_600_000, BUS_CLK=100_000, so DIVIDER=4. The bench models a pull-up: line = ~oe & device_drive.
- Reset, then START: both oe 0 during reset; sda_oe rises 8 cycles after accept, scl_oe 4 cycles later; rsp_valid 16 cycles after accept; busy=1.
- WRITE 0xA5, slave pulls SDA low in bit 9: sda_oe sequence per bit is 0,1,0,1,1,0,1,0 then 0; rsp_nack=0; rsp_valid 144 cycles after accept.
- READ, slave drives 0x3C, cmd_nack=1: rd_data=0x3C; sda_oe=0 in bit 9; rsp_nack=0.
- Slave holds SCL low 20 cycles in ph2 of bit 3 of a WRITE: rsp_valid delayed by exactly 22 cycles; no sample taken before release.
- WRITE while idle: rsp_err=1 on the cycle after accept; oe never asserted. Then START, START (repeated start), STOP: busy ends at 0 and both lines are released.
- Assert rst mid-READ bit 5: scl_oe and sda_oe are 0 within the same cycle; cmd_ready=1 and busy=0 after release.
